rx_interface: RTL and testbench
===============================

RX_INTERFACE -- requirements
Module: rx_interface

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: idle clocks allowed between bytes of one frame (used only when RX_TIMEOUT_EN is defined).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_done_tick  input  1  one-cycle strobe from UART receiver; dout valid in that cycle.
REQ-005 dout  input  8  received byte.
REQ-006 a  output  8  signed operand A to ALU, registered.
REQ-007 b  output  8  signed operand B to ALU, registered.
REQ-008 op  output  6  ALU opcode, registered.
REQ-009 done_tick  output  1  one-cycle pulse: new a/b/op valid.
REQ-010 timeout_tick  output  1  one-cycle pulse: partial frame discarded.

Function
REQ-011 A frame SHALL be three bytes in order: A, B, OP.
REQ-012 FSM states SHALL be S_A (await A), S_B (await B), S_OP (await OP); only rx_done_tick or timeout advances it.
REQ-013 S_A + rx_done_tick: SHALL capture dout into staging register sa, go to S_B.
REQ-014 S_B + rx_done_tick: SHALL capture dout into staging register sb, go to S_OP.
REQ-015 S_OP + rx_done_tick: SHALL load a<=sa, b<=sb, op<=dout[5:0] on the same edge, go to S_A; dout[7:6] ignored.
REQ-016 done_tick SHALL be high exactly in the cycle after the OP-capturing edge (1-cycle latency from OP strobe), coincident with new a/b/op first visible.
REQ-017 a, b, op SHALL change only atomically per REQ-015; partial frames never disturb them.
REQ-018 a, b, op SHALL hold their value indefinitely until the next complete frame.
REQ-019 Back-to-back strobes in consecutive cycles SHALL each be accepted; no byte dropped.
REQ-020 rx_done_tick low: dout SHALL be ignored, state unchanged (except timeout counting).
REQ-021 done_tick and timeout_tick SHALL never be high in the same cycle.

Reset
REQ-022 While reset is high at a clk edge: state<=S_A, sa=sb=0, a=b=0, op=0, done_tick=0, timeout_tick=0, timeout counter=0.
REQ-023 Reset mid-frame SHALL discard the partial frame without a done_tick; reset has priority over rx_done_tick in the same cycle.

Configuration
REQ-024 Macro RX_TIMEOUT_EN SHALL compile in an inter-byte timeout.
REQ-025 With RX_TIMEOUT_EN: counter clears on every rx_done_tick and in S_A, increments each cycle in S_B/S_OP without a strobe; at TIMEOUT_CYCLES-1 it SHALL return FSM to S_A, clear the counter, and pulse timeout_tick one cycle later; a, b, op unchanged.
REQ-026 With RX_TIMEOUT_EN: a strobe in the same cycle the counter reaches its limit SHALL be accepted as a byte; no timeout.
REQ-027 Without RX_TIMEOUT_EN: no counter logic, timeout_tick tied to 0, partial frames wait forever; port list identical.

Verification
REQ-028 Reset, then strobes 0x05, 0xFD, 0x20 spaced 10 cycles -> a=5, b=-3, op=6'h20, done_tick high one cycle after third strobe.
REQ-029 Strobes 0x7F, 0x80, 0xE3 in three consecutive cycles -> a=127, b=-128, op=6'h23, one done_tick.
REQ-030 Frame 0x01,0x02,0x03 complete, then 0x09,0x0A only -> a=1, b=2, op=3 held, no second done_tick.
REQ-031 Reset asserted after A=0x11 received, then 0x04,0x06,0x22 -> a=4, b=6, op=6'h22; 0x11 never appears.
REQ-032 RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: byte 0x07, 20 idle cycles -> timeout_tick pulse, state S_A; then 0x02,0x03,0x24 -> a=2, b=3, op=6'h24.
REQ-033 RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: second byte exactly at limit cycle -> accepted, no timeout_tick.

Source files
------------

// File: rtl/rx_interface.sv
// Collects UART bytes A, B, OP into one registered ALU operand set with a done strobe.
// Define RX_TIMEOUT_EN to discard a partial frame after TIMEOUT_CYCLES idle clocks.
module rx_interface #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [7:0]        dout,
    output logic signed [7:0] a,
    output logic signed [7:0] b,
    output logic [5:0]        op,
    output logic              done_tick,
    output logic              timeout_tick
);

    typedef enum logic [1:0] {S_A, S_B, S_OP} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_sa, r_sb;
    logic [7:0]  r_a, r_b;
    logic [5:0]  r_op;
    logic        r_done;
    logic        w_load;
    logic        w_timeout;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_A:     if (rx_done_tick) w_next = S_B;
            S_B:     if (rx_done_tick) w_next = S_OP;
                     else if (w_timeout) w_next = S_A;
            S_OP:    if (rx_done_tick) begin
                         w_next = S_A;
                         w_load = 1'b1;
                     end else if (w_timeout) w_next = S_A;
            default: w_next = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_A;
            r_sa    <= '0;
            r_sb    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_load;
            if (rx_done_tick && r_state == S_A) r_sa <= dout;
            if (rx_done_tick && r_state == S_B) r_sb <= dout;
            // Operands only ever move together, on the OP byte.
            if (w_load) begin
                r_a  <= r_sa;
                r_b  <= r_sb;
                r_op <= dout[5:0];
            end
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_to;

    // A strobe arriving on the limit cycle wins over the timeout.
    assign w_timeout = (r_state != S_A) && !rx_done_tick && (r_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            r_to <= w_timeout;
            if (rx_done_tick || r_state == S_A || w_timeout) r_cnt <= '0;
            else                                               r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout_tick = r_to;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
    assign timeout_tick = 1'b0;
`endif

    assign a         = r_a;
    assign b         = r_b;
    assign op        = r_op;
    assign done_tick = r_done;

endmodule

// File: tb/tb_rx_interface.sv
// Directed bench for rx_interface: frame-level model checked every cycle plus literal spot checks.
module tb_rx_interface;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_done_tick = 1'b0;
    logic [7:0]        dout = 8'h00;
    logic signed [7:0] a, b;
    logic [5:0]        op;
    logic              done_tick, timeout_tick;

    localparam int TO = 16;

    rx_interface #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .dout(dout),
        .a(a), .b(b), .op(op), .done_tick(done_tick), .timeout_tick(timeout_tick)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_done = 0, n_to = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: bytes gathered into a list; third byte publishes the frame.
    int  m_bytes[3];
    int  m_n = 0, m_idle = 0;
    int  ea = 0, eb = 0, eop = 0, edone = 0, eto = 0;

    always @(posedge clk) begin
        edone = 0;
        eto   = 0;
        if (reset) begin
            m_n = 0; m_idle = 0; ea = 0; eb = 0; eop = 0;
        end else if (rx_done_tick) begin
            m_bytes[m_n] = int'(dout);
            m_n++;
            m_idle = 0;
            if (m_n == 3) begin
                ea    = int'($signed(m_bytes[0][7:0]));
                eb    = int'($signed(m_bytes[1][7:0]));
                eop   = m_bytes[2] % 64;
                edone = 1;
                m_n   = 0;
            end
        end else if (m_n > 0) begin
            m_idle++;
`ifdef RX_TIMEOUT_EN
            if (m_idle == TO) begin
                m_n = 0; m_idle = 0; eto = 1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_a", int'(a), ea);
            chk("cyc_b", int'(b), eb);
            chk("cyc_op", int'(op), eop);
            chk("cyc_done", int'(done_tick), edone);
            chk("cyc_timeout", int'(timeout_tick), eto);
            if (done_tick) n_done++;
            if (timeout_tick) n_to++;
        end
    end

    task automatic strobe(input logic [7:0] v);
        rx_done_tick = 1'b1;
        dout = v;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        dout = 8'hAA;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int d0, t0;

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_op", int'(op), 0);
        chk("rst_done", int'(done_tick), 0);
        chk("rst_timeout", int'(timeout_tick), 0);

        // Spaced frame with a negative operand.
        idle(3);
        strobe(8'h05); idle(9);
        strobe(8'hFD); idle(9);
        strobe(8'h20);
        chk("f1_done_latency", int'(done_tick), 1);
        chk("f1_a", int'(a), 5);
        chk("f1_b", int'(b), -3);
        chk("f1_op", int'(op), 32);
        idle(1);
        chk("f1_done_once", int'(done_tick), 0);

        // Back-to-back strobes, top bits of OP dropped.
        idle(4);
        d0 = n_done;
        strobe(8'h7F); strobe(8'h80); strobe(8'hE3);
        idle(3);
        chk("f2_a", int'(a), 127);
        chk("f2_b", int'(b), -128);
        chk("f2_op", int'(op), 35);
        chk("f2_ndone", n_done - d0, 1);

        // Complete frame then a partial one: outputs hold.
        d0 = n_done;
        strobe(8'h01); strobe(8'h02); strobe(8'h03);
        idle(2);
        strobe(8'h09); strobe(8'h0A);
        idle(30);
        chk("f3_a", int'(a), 1);
        chk("f3_b", int'(b), 2);
        chk("f3_op", int'(op), 3);
        chk("f3_ndone", n_done - d0, 1);

        do_reset();
        idle(2);
`ifdef RX_TIMEOUT_EN
        // Lone byte then silence: frame dropped, outputs untouched.
        t0 = n_to; d0 = n_done;
        strobe(8'h07);
        idle(20);
        chk("to_ntimeout", n_to - t0, 1);
        chk("to_a_held", int'(a), 0);
        strobe(8'h02); strobe(8'h03); strobe(8'h24);
        idle(2);
        chk("to_a", int'(a), 2);
        chk("to_b", int'(b), 3);
        chk("to_op", int'(op), 36);
        chk("to_ndone", n_done - d0, 1);

        // Second byte lands on the limit cycle and must be kept.
        t0 = n_to;
        strobe(8'h10);
        idle(TO - 1);
        strobe(8'h20);
        strobe(8'h30);
        idle(2);
        chk("lim_ntimeout", n_to - t0, 0);
        chk("lim_a", int'(a), 16);
        chk("lim_b", int'(b), 32);
        chk("lim_op", int'(op), 48);
`else
        // Without the timeout a partial frame waits indefinitely.
        d0 = n_done;
        strobe(8'h07);
        idle(40);
        chk("wait_ndone", n_done - d0, 0);
        strobe(8'h02); strobe(8'h03);
        idle(2);
        chk("wait_a", int'(a), 7);
        chk("wait_b", int'(b), 2);
        chk("wait_op", int'(op), 3);
        chk("wait_ntimeout", n_to, 0);
`endif

        // Reset mid-frame, colliding with a strobe, discards everything pending.
        do_reset();
        d0 = n_done;
        strobe(8'h11);
        idle(2);
        reset = 1'b1;
        rx_done_tick = 1'b1;
        dout = 8'h55;
        @(posedge clk); #1;
        reset = 1'b0;
        rx_done_tick = 1'b0;
        idle(2);
        strobe(8'h04); strobe(8'h06); strobe(8'h22);
        idle(2);
        chk("rm_a", int'(a), 4);
        chk("rm_b", int'(b), 6);
        chk("rm_op", int'(op), 34);
        chk("rm_ndone", n_done - d0, 1);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
